counter_ud_4b: RTL and testbench

Synchronous loadable up/down binary counter, the down-counting counterpart of the existing 4-bit up counter. Used wherever the CPU must count toward zero: stack pointer decrement, loop/step countdown, and stepping back through addresses. Widths cascade through a terminal-count output that is valid in both count directions.

---
 rtl/counter_ud_4b.sv | 63 ++++++
 tb/tb_counter_ud_4b.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/counter_ud_4b.sv
`default_nettype none
// ============================================================================
// Module      : counter_ud_4b
// Description : Synchronous loadable up/down binary counter with asynchronous
//               clear, parallel/trickle enables and a direction-aware terminal
//               count output for cascading wider counters from 4-bit stages.
// Revision    : 1.0 - initial release
// ============================================================================
module counter_ud_4b #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             ld_n,
  input  logic             p_en,
  input  logic             t_en,
  input  logic             up,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             tc_out,
  output logic             zero
);

  localparam logic [WIDTH-1:0] c_ONE  = WIDTH'(1);
  localparam logic [WIDTH-1:0] c_ONES = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] c_ZERO = '0;

  // The counter value is the only state; data_out is driven straight from it.
  logic [WIDTH-1:0] r_count;
  logic             w_count_en;
  logic             w_at_ones;
  logic             w_at_zero;

  // Both enables must be high to step; a low enable masks X on the other one.
  assign w_count_en = p_en & t_en;
  assign w_at_ones  = (r_count == c_ONES);
  assign w_at_zero  = (r_count == c_ZERO);

  // Count register: clear wins asynchronously, then load, then count, else hold.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_count <= c_ZERO;
    end else if (!ld_n) begin
      r_count <= data_in;
    end else if (w_count_en) begin
      if (up) begin
        r_count <= r_count + c_ONE;
      end else begin
        r_count <= r_count - c_ONE;
      end
    end
  end

  assign data_out = r_count;

  // Terminal count follows the current direction with no latency, so the next
  // stage steps exactly on this stage's wrap edge whether counting up or down.
  assign tc_out = t_en & ((up & w_at_ones) | (~up & w_at_zero));

  assign zero = w_at_zero;

endmodule
`default_nettype wire

// File: tb/tb_counter_ud_4b.sv
`default_nettype none
// ============================================================================
// Module      : tb_counter_ud_4b
// Description : Self-checking bench for counter_ud_4b: single 4-bit instance
//               plus an 8-bit cascade of two instances, scoreboard driven.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_counter_ud_4b;

  typedef struct {
    string      tag;
    logic [7:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // single instance stimulus / observation
  logic       clr_n, ld_n, p_en, t_en, up;
  logic [3:0] data_in, data_out;
  logic       tc_out, zero;

  // cascade stimulus / observation
  logic       c_ld_n, c_p_en, c_t_en, c_up;
  logic [7:0] c_data_in;
  logic [3:0] c_lo_q, c_hi_q;
  logic       c_lo_tc, c_hi_tc, c_lo_zero, c_hi_zero;

  int n_checks = 0;
  int n_errors = 0;

  exp_t sb[$];
  exp_t csb[$];
  logic [3:0] m_cnt;
  logic [7:0] c_m_cnt;

  counter_ud_4b #(.WIDTH(4)) u_dut (
    .clk(clk), .clr_n(clr_n), .ld_n(ld_n), .p_en(p_en), .t_en(t_en),
    .up(up), .data_in(data_in), .data_out(data_out), .tc_out(tc_out),
    .zero(zero)
  );

  counter_ud_4b #(.WIDTH(4)) u_lo (
    .clk(clk), .clr_n(clr_n), .ld_n(c_ld_n), .p_en(c_p_en), .t_en(c_t_en),
    .up(c_up), .data_in(c_data_in[3:0]), .data_out(c_lo_q), .tc_out(c_lo_tc),
    .zero(c_lo_zero)
  );

  counter_ud_4b #(.WIDTH(4)) u_hi (
    .clk(clk), .clr_n(clr_n), .ld_n(c_ld_n), .p_en(c_p_en), .t_en(c_lo_tc),
    .up(c_up), .data_in(c_data_in[7:4]), .data_out(c_hi_q), .tc_out(c_hi_tc),
    .zero(c_hi_zero)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic model_tc4(input logic t, input logic u, input logic [3:0] c);
    return t & ((u & (c == 4'hF)) | (~u & (c == 4'h0)));
  endfunction

  function automatic logic model_tc8(input logic t, input logic u, input logic [7:0] c);
    return t & ((u & (c == 8'hFF)) | (~u & (c == 8'h00)));
  endfunction

  // one clock of the single counter: push expectation, clock, pop and compare
  task automatic step(input string tag, input logic l, input logic p, input logic t,
                      input logic u, input logic [3:0] d);
    exp_t       e;
    logic [3:0] nxt;
    ld_n = l; p_en = p; t_en = t; up = u; data_in = d;
    if (!l)           nxt = d;
    else if (p & t)   nxt = u ? m_cnt + 4'd1 : m_cnt - 4'd1;
    else              nxt = m_cnt;
    e.tag = tag;
    e.cnt = {4'h0, nxt};
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    m_cnt = e.cnt[3:0];
    check_eq({e.tag, " q"}, {28'h0, data_out}, {28'h0, m_cnt});
    check_eq({e.tag, " tc"}, {31'h0, tc_out}, {31'h0, model_tc4(t, u, m_cnt)});
    check_eq({e.tag, " zero"}, {31'h0, zero}, {31'h0, (m_cnt == 4'h0)});
  endtask

  // one clock of the 8-bit cascade
  task automatic cstep(input string tag, input logic l, input logic p, input logic t,
                       input logic u, input logic [7:0] d);
    exp_t e;
    c_ld_n = l; c_p_en = p; c_t_en = t; c_up = u; c_data_in = d;
    e.tag = tag;
    if (!l)         e.cnt = d;
    else if (p & t) e.cnt = u ? c_m_cnt + 8'd1 : c_m_cnt - 8'd1;
    else            e.cnt = c_m_cnt;
    csb.push_back(e);
    @(posedge clk);
    #1;
    e = csb.pop_front();
    c_m_cnt = e.cnt;
    check_eq({e.tag, " q"}, {24'h0, c_hi_q, c_lo_q}, {24'h0, c_m_cnt});
    check_eq({e.tag, " tc"}, {31'h0, c_hi_tc}, {31'h0, model_tc8(t, u, c_m_cnt)});
  endtask

  // watchdog: the run is a few thousand cycles at most
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    clr_n = 1'b0; ld_n = 1'b1; p_en = 1'b0; t_en = 1'b1; up = 1'b0; data_in = 4'h0;
    c_ld_n = 1'b1; c_p_en = 1'b0; c_t_en = 1'b1; c_up = 1'b0; c_data_in = 8'h00;
    m_cnt = 4'h0;
    c_m_cnt = 8'h00;

    // reset state
    #1;
    check_eq("rst q", {28'h0, data_out}, 32'h0);
    check_eq("rst zero", {31'h0, zero}, 32'h1);
    check_eq("rst tc", {31'h0, tc_out}, 32'h1);
    check_eq("rst casc q", {24'h0, c_hi_q, c_lo_q}, 32'h0);

    // edges while clear is held are ignored, even with a load pending
    ld_n = 1'b0; data_in = 4'h5; p_en = 1'b1;
    @(posedge clk); #1;
    check_eq("rst edge q", {28'h0, data_out}, 32'h0);
    clr_n = 1'b1;
    #1;
    check_eq("rst release q", {28'h0, data_out}, 32'h0);

    // asynchronous clear between edges
    step("ld A", 1'b0, 1'b0, 1'b0, 1'b1, 4'hA);
    up = 1'b0; t_en = 1'b1; ld_n = 1'b0; data_in = 4'hF;
    #2 clr_n = 1'b0;
    #1;
    check_eq("aclr q", {28'h0, data_out}, 32'h0);
    check_eq("aclr zero", {31'h0, zero}, 32'h1);
    check_eq("aclr tc", {31'h0, tc_out}, 32'h1);
    @(posedge clk); #1;
    check_eq("aclr hold q", {28'h0, data_out}, 32'h0);
    clr_n = 1'b1;
    m_cnt = 4'h0;

    // load has priority over counting
    step("ld pri", 1'b0, 1'b1, 1'b1, 1'b1, 4'h7);
    step("up 8", 1'b1, 1'b1, 1'b1, 1'b1, 4'h0);
    step("up 9", 1'b1, 1'b1, 1'b1, 1'b1, 4'h0);

    // down count through zero
    step("ld 2", 1'b0, 1'b1, 1'b1, 1'b0, 4'h2);
    for (int i = 0; i < 4; i++) step("down", 1'b1, 1'b1, 1'b1, 1'b0, 4'h0);

    // up wrap and trickle gating
    step("ld E", 1'b0, 1'b1, 1'b1, 1'b1, 4'hE);
    step("up F", 1'b1, 1'b1, 1'b1, 1'b1, 4'h0);
    step("ten0 hold", 1'b1, 1'b1, 1'b0, 1'b1, 4'h0);
    step("up wrap", 1'b1, 1'b1, 1'b1, 1'b1, 4'h0);

    // direction flip and parallel-enable hold
    step("ld 3", 1'b0, 1'b1, 1'b1, 1'b1, 4'h3);
    step("up 4", 1'b1, 1'b1, 1'b1, 1'b1, 4'h0);
    step("flip 3", 1'b1, 1'b1, 1'b1, 1'b0, 4'h0);
    for (int i = 0; i < 3; i++) step("pen0 hold", 1'b1, 1'b0, 1'b1, 1'b0, 4'h0);

    // X on direction/data with enables low must not disturb the count
    step("x hold", 1'b1, 1'b0, 1'b0, 1'bx, 4'hx);

    // random single-stage traffic
    for (int i = 0; i < 60; i++) begin
      step("rand", ($urandom_range(0, 7) != 0), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
    end
    ld_n = 1'b1; p_en = 1'b0; t_en = 1'b0; up = 1'b0;

    // 8-bit cascade
    cstep("c ld 00", 1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
    cstep("c dn FF", 1'b1, 1'b1, 1'b1, 1'b0, 8'h00);
    cstep("c dn FE", 1'b1, 1'b1, 1'b1, 1'b0, 8'h00);
    cstep("c ld 0F", 1'b0, 1'b1, 1'b1, 1'b1, 8'h0F);
    cstep("c up 10", 1'b1, 1'b1, 1'b1, 1'b1, 8'h00);
    for (int i = 0; i < 256; i++) cstep("c run up", 1'b1, 1'b1, 1'b1, 1'b1, 8'h00);
    for (int i = 0; i < 256; i++) cstep("c run dn", 1'b1, 1'b1, 1'b1, 1'b0, 8'h00);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
